bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, minimum active-phase length minus one (legal range 0..15).
REQ-002 SHALL have parameter TURN_CYCLES, default 1, dead cycles with the bus disabled on a direction change (legal range 0..3).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, ready-wait limit; used only under BUSCTL_TIMEOUT_EN.
REQ-004 SHALL have ports: clk in 1, rising-edge clock. One clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: req_valid in 1, transfer request.
REQ-007 SHALL have ports: req_write in 1, 1 = A->B write, 0 = B->A read.
REQ-008 SHALL have ports: req_wdata in 8, write data.
REQ-009 SHALL have ports: req_ready out 1, request accepted when high together with req_valid.
REQ-010 SHALL have ports: rsp_valid out 1, one-cycle completion pulse.
REQ-011 SHALL have ports: rsp_rdata out 8, read data.
REQ-012 SHALL have ports: rsp_err out 1, timeout flag.
REQ-013 SHALL have ports: bus_dir out 1, transceiver DIR; 1 = A->B.
REQ-014 SHALL have ports: bus_noe out 1, transceiver output enable, active-low.
REQ-015 SHALL have ports: bus_wdata out 8, A-side drive data.
REQ-016 SHALL have ports: bus_rdata in 8, A-side sampled data.
REQ-017 SHALL have ports: bus_rdy in 1, external ready; low inserts wait states.

Function
REQ-018 SHALL implement states IDLE, TURN, ACTIVE, DONE.
REQ-019 SHALL assert req_ready only in IDLE; accept = req_valid & req_ready; latch req_write and req_wdata on accept.
REQ-020 SHALL, on accept with req_write != bus_dir and TURN_CYCLES > 0, update bus_dir at the next edge and enter TURN for exactly TURN_CYCLES cycles; otherwise enter ACTIVE directly, updating bus_dir on entry.
REQ-021 SHALL hold bus_noe = 1 in IDLE, TURN and DONE, and bus_noe = 0 only in ACTIVE.
REQ-022 SHALL keep bus_dir constant in ACTIVE and while bus_noe = 0; it changes only when leaving IDLE.
REQ-023 SHALL stay in ACTIVE for at least WAIT_CYCLES+1 cycles, then remain there until bus_rdy = 1 is sampled, checked first on cycle WAIT_CYCLES+1 of ACTIVE.
REQ-024 SHALL, on the ACTIVE exit edge of a read, capture bus_rdata into rsp_rdata; writes leave rsp_rdata unchanged.
REQ-025 SHALL spend exactly one cycle in DONE with rsp_valid = 1, then return to IDLE; there is no response backpressure.
REQ-026 SHALL drive bus_wdata from the latched write data; it is held between transfers.
REQ-027 SHALL give same-direction latency (accept edge to rsp_valid) of WAIT_CYCLES+2 cycles with bus_rdy high, plus TURN_CYCLES on a direction change.
REQ-028 SHALL ignore req_valid outside IDLE; back-to-back requests are accepted no sooner than the cycle after DONE.

Reset
REQ-029 SHALL, on rst, enter IDLE at the next edge: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, bus_dir=0, bus_noe=1, bus_wdata=0, counters=0.
REQ-030 SHALL make rst asserted mid-transfer abort it with no rsp_valid; bus_noe returns to 1 at that edge.

Configuration
REQ-031 SHALL, with BUSCTL_TIMEOUT_EN defined, count ready-wait cycles in ACTIVE after the minimum phase; when the count reaches TIMEOUT_CYCLES with bus_rdy still 0, enter DONE with rsp_err=1 and rsp_rdata=0.
REQ-032 SHALL, without BUSCTL_TIMEOUT_EN, wait indefinitely for bus_rdy, tie rsp_err to 0, and ignore TIMEOUT_CYCLES.
REQ-033 SHALL clear rsp_err when the next request is accepted.

Structure
REQ-034 SHALL place the state enum and default WAIT/TURN/TIMEOUT constants in shared package busctl_pkg.
REQ-035 SHALL implement the wait/turn/timeout down-counter as one sub-module, busctl_cnt (load, decrement, zero flag).

Verification
REQ-036 SHALL verify: after reset, read with WAIT_CYCLES=1 and bus_rdy=1, bus_rdata=0xA5 -> bus_noe low 2 cycles, rsp_valid 3 cycles after accept, rsp_rdata=0xA5.
REQ-037 SHALL verify: a write of 0x3C from the read state with TURN_CYCLES=1 -> bus_dir rises while bus_noe=1, then 1 TURN cycle, ACTIVE shows bus_wdata=0x3C, rsp_valid 4 cycles after accept.
REQ-038 SHALL verify: bus_rdy held low 5 extra cycles -> ACTIVE extended by 5, then normal completion with rsp_err=0.
REQ-039 SHALL verify: with BUSCTL_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus_rdy stuck 0 -> rsp_valid=1, rsp_err=1, rsp_rdata=0; the next request clears rsp_err.
REQ-040 SHALL verify: rst asserted in the 2nd ACTIVE cycle -> no rsp_valid, bus_noe=1 and bus_dir=0 next cycle, req_ready=1.
REQ-041 SHALL verify: req_valid held high continuously -> no accept outside IDLE, and bus_noe never low during any bus_dir change.

Source files
------------

// File: rtl/busctl_pkg.sv
// Shared types and defaults for the bus transfer controller.
// The ready-wait timeout is enabled by defining BUSCTL_TIMEOUT_EN.
package busctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_ACTIVE,
        ST_DONE
    } state_e;

    localparam int WAIT_CYCLES_DEF    = 1;
    localparam int TURN_CYCLES_DEF    = 1;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int CNT_W              = 8;

    // Saturating conversion of a cycle count into a counter load value.
    function automatic logic [CNT_W-1:0] to_cnt(input int v);
        logic [CNT_W-1:0] r;
        if (v <= 0) begin
            r = '0;
        end else if (v >= (2 ** CNT_W) - 1) begin
            r = '1;
        end else begin
            r = CNT_W'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/busctl_cnt.sv
// Loadable down-counter shared by the turn, wait and timeout phases.
// Decrement saturates at zero; zero flag reflects the registered count.
module busctl_cnt
    import busctl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Single-transfer controller for a bidirectional bus transceiver.
// Define BUSCTL_TIMEOUT_EN to abort transfers stuck waiting for bus_rdy.
module bus_xfer_ctrl
    import busctl_pkg::*;
#(
    parameter int WAIT_CYCLES    = WAIT_CYCLES_DEF,
    parameter int TURN_CYCLES    = TURN_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       bus_dir,
    output logic       bus_noe,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_rdy
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = to_cnt(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] TURN_LOAD = to_cnt(TURN_CYCLES - 1);

    state_e     state_q, state_d;
    logic       wr_q, wr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       dir_q, dir_d;
    logic       noe_q, noe_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             min_busy;

`ifdef BUSCTL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = to_cnt(TIMEOUT_CYCLES - 2);

    logic waiting_q, waiting_d;

    // The counter is reused: first the minimum phase, then ready-wait.
    assign min_busy = !cnt_zero && !waiting_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign min_busy       = !cnt_zero;
`endif

    busctl_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        dir_d    = dir_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
`ifdef BUSCTL_TIMEOUT_EN
        waiting_d = waiting_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d     = req_write;
                    wdata_d  = req_wdata;
                    err_d    = 1'b0;
                    dir_d    = req_write;
                    cnt_load = 1'b1;
`ifdef BUSCTL_TIMEOUT_EN
                    waiting_d = 1'b0;
`endif
                    if ((req_write != dir_q) && (TURN_CYCLES > 0)) begin
                        state_d = ST_TURN;
                        cnt_val = TURN_LOAD;
                    end else begin
                        state_d = ST_ACTIVE;
                        cnt_val = WAIT_LOAD;
                    end
                end
            end

            ST_TURN: begin
                if (cnt_zero) begin
                    state_d  = ST_ACTIVE;
                    cnt_load = 1'b1;
                    cnt_val  = WAIT_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (min_busy) begin
                    cnt_dec = 1'b1;
                end else if (bus_rdy) begin
                    state_d = ST_DONE;
                    if (!wr_q) begin
                        rdata_d = bus_rdata;
                    end
`ifdef BUSCTL_TIMEOUT_EN
                end else if (!waiting_q) begin
                    if (TIMEOUT_CYCLES <= 1) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        waiting_d = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = TO_LOAD;
                    end
                end else if (cnt_zero) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_dec = 1'b1;
`endif
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        noe_d       = (state_d != ST_ACTIVE);
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            dir_q       <= 1'b0;
            noe_q       <= 1'b1;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef BUSCTL_TIMEOUT_EN
            waiting_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            dir_q       <= dir_d;
            noe_q       <= noe_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef BUSCTL_TIMEOUT_EN
            waiting_q   <= waiting_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign bus_dir   = dir_q;
    assign bus_noe   = noe_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed self-checking bench for bus_xfer_ctrl (WAIT=1, TURN=1).
// Timeout scenario runs only when BUSCTL_TIMEOUT_EN is defined.
module tb_bus_xfer_ctrl;

    localparam int WAIT = 1;
    localparam int TURN = 1;
`ifdef BUSCTL_TIMEOUT_EN
    localparam int XTRA = 3;
`else
    localparam int XTRA = 5;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       bus_dir;
    logic       bus_noe;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_rdy = 1'b1;

    int checks = 0;
    int failures = 0;

    bus_xfer_ctrl #(
        .WAIT_CYCLES    (WAIT),
        .TURN_CYCLES    (TURN),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_dir   (bus_dir),
        .bus_noe   (bus_noe),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rdy   (bus_rdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        bus_rdy = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Issues one request in the current (IDLE) cycle and observes it.
    task automatic run_xfer(
        input  logic       w,
        input  logic [7:0] d,
        input  int         rdy_low,
        output int         lat,
        output int         noe_low,
        output int         dir_chg,
        output logic [7:0] wd_act,
        output logic [7:0] rd,
        output logic       er,
        output int         glitch
    );
        logic pdir;
        int   n;
        lat = -1;
        dir_chg = -1;
        glitch = 0;
        wd_act = 8'hxx;
        rd = 8'hxx;
        er = 1'bx;
        n = 0;
        pdir = bus_dir;
        req_valid = 1'b1;
        req_write = w;
        req_wdata = d;
        for (int c = 1; c <= 80 && lat < 0; c++) begin
            step();
            req_valid = 1'b0;
            if (bus_dir !== pdir) begin
                dir_chg = c;
                if (bus_noe !== 1'b1) glitch++;
            end
            pdir = bus_dir;
            if (bus_noe === 1'b0) begin
                n++;
                if (n == 1) wd_act = bus_wdata;
                bus_rdy = (n >= WAIT + 1 + rdy_low);
            end
            if (rsp_valid === 1'b1) begin
                lat = c;
                rd = rsp_rdata;
                er = rsp_err;
            end
        end
        bus_rdy = 1'b1;
        noe_low = n;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
        end
        checks++;
        if (bus_noe !== 1'b1 || bus_dir !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus got noe=%b dir=%b exp noe=1 dir=0",
                     bus_noe, bus_dir);
        end
        checks++;
        if (rsp_rdata !== 8'h00 || bus_wdata !== 8'h00 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h wdata=%h err=%b exp 00/00/0",
                     rsp_rdata, bus_wdata, rsp_err);
        end
    endtask

    task automatic test_read();
        int lat, nl, dc, gl;
        logic [7:0] wa, rd;
        logic er;
        bus_rdata = 8'hA5;
        run_xfer(1'b0, 8'h00, 0, lat, nl, dc, wa, rd, er, gl);
        checks++;
        if (lat != WAIT + 2) begin
            failures++;
            $display("FAIL read_latency got=%0d exp=%0d", lat, WAIT + 2);
        end
        checks++;
        if (nl != 2) begin
            failures++;
            $display("FAIL read_noe_low got=%0d exp=2", nl);
        end
        checks++;
        if (rd !== 8'hA5 || er !== 1'b0) begin
            failures++;
            $display("FAIL read_data got=%h err=%b exp=a5 err=0", rd, er);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL read_done_pulse got valid=%b ready=%b exp 0/1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_write_turn();
        int lat, nl, dc, gl;
        logic [7:0] wa, rd;
        logic er;
        bus_rdata = 8'hFF;
        run_xfer(1'b1, 8'h3C, 0, lat, nl, dc, wa, rd, er, gl);
        checks++;
        if (lat != WAIT + 2 + TURN) begin
            failures++;
            $display("FAIL write_latency got=%0d exp=%0d", lat, WAIT + 2 + TURN);
        end
        checks++;
        if (dc != 1 || gl != 0) begin
            failures++;
            $display("FAIL write_dir_change got cycle=%0d glitch=%0d exp 1/0",
                     dc, gl);
        end
        checks++;
        if (wa !== 8'h3C || nl != 2) begin
            failures++;
            $display("FAIL write_active got wdata=%h noe_low=%0d exp 3c/2",
                     wa, nl);
        end
        checks++;
        if (rd !== 8'hA5 || bus_dir !== 1'b1) begin
            failures++;
            $display("FAIL write_hold got rdata=%h dir=%b exp a5/1", rd, bus_dir);
        end
        step();
    endtask

    task automatic test_wait_states();
        int lat, nl, dc, gl;
        logic [7:0] wa, rd;
        logic er;
        run_xfer(1'b1, 8'h81, XTRA, lat, nl, dc, wa, rd, er, gl);
        checks++;
        if (nl != WAIT + 1 + XTRA) begin
            failures++;
            $display("FAIL wait_noe_low got=%0d exp=%0d", nl, WAIT + 1 + XTRA);
        end
        checks++;
        if (lat != WAIT + 2 + XTRA) begin
            failures++;
            $display("FAIL wait_latency got=%0d exp=%0d", lat, WAIT + 2 + XTRA);
        end
        checks++;
        if (er !== 1'b0 || rd !== 8'hA5 || bus_wdata !== 8'h81) begin
            failures++;
            $display("FAIL wait_result got err=%b rdata=%h wdata=%h exp 0/a5/81",
                     er, rd, bus_wdata);
        end
        step();
    endtask

`ifdef BUSCTL_TIMEOUT_EN
    task automatic test_timeout();
        int lat, nl, dc, gl;
        logic [7:0] wa, rd;
        logic er;
        bit seen;
        bus_rdata = 8'hC3;
        run_xfer(1'b0, 8'h00, 1000, lat, nl, dc, wa, rd, er, gl);
        checks++;
        if (lat != 7 || nl != 5) begin
            failures++;
            $display("FAIL timeout_timing got lat=%0d noe_low=%0d exp 7/5",
                     lat, nl);
        end
        checks++;
        if (er !== 1'b1 || rd !== 8'h00) begin
            failures++;
            $display("FAIL timeout_result got err=%b rdata=%h exp 1/00", er, rd);
        end
        step();
        bus_rdata = 8'h77;
        req_valid = 1'b1;
        req_write = 1'b0;
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err_clear got=%b exp=0", rsp_err);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen || rsp_rdata !== 8'h77 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_recover got seen=%b rdata=%h err=%b exp 1/77/0",
                     seen, rsp_rdata, rsp_err);
        end
        step();
    endtask
`endif

    task automatic test_abort();
        int nv;
        do_reset();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 8'h11;
        step();
        req_valid = 1'b0;
        step();
        step();
        checks++;
        if (bus_noe !== 1'b0 || bus_dir !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre got noe=%b dir=%b exp 0/1", bus_noe, bus_dir);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus_noe !== 1'b1 || bus_dir !== 1'b0 || req_ready !== 1'b1
            || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got noe=%b dir=%b ready=%b valid=%b exp 1/0/1/0",
                     bus_noe, bus_dir, req_ready, rsp_valid);
        end
        nv = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (rsp_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 0 || bus_wdata !== 8'h00) begin
            failures++;
            $display("FAIL abort_no_rsp got pulses=%0d wdata=%h exp 0/00",
                     nv, bus_wdata);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int glitch, dchg;
        logic pdir;
        bit tog;
        do_reset();
        glitch = 0;
        dchg = 0;
        tog = 1'b0;
        pdir = bus_dir;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 8'h5A;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                step();
                if (tog) begin
                    req_write = ~req_write;
                    tog = 1'b0;
                end
            end
            if (bus_dir !== pdir) begin
                dchg++;
                if (bus_noe !== 1'b1) glitch++;
            end
            pdir = bus_dir;
            if (req_ready === 1'b1) begin
                acc.push_back(c);
                tog = 1'b1;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (acc.size() != 4) begin
            failures++;
            $display("FAIL b2b_accept_count got=%0d exp=4", acc.size());
        end else begin
            checks++;
            if (acc[0] != 0 || acc[1] != 5 || acc[2] != 10 || acc[3] != 15) begin
                failures++;
                $display("FAIL b2b_accept_cycles got=%0d,%0d,%0d,%0d exp=0,5,10,15",
                         acc[0], acc[1], acc[2], acc[3]);
            end
        end
        checks++;
        if (dchg != 4 || glitch != 0) begin
            failures++;
            $display("FAIL b2b_dir got changes=%0d glitches=%0d exp 4/0",
                     dchg, glitch);
        end
        for (int c = 0; c < 6; c++) step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_turn();
        test_wait_states();
`ifdef BUSCTL_TIMEOUT_EN
        test_timeout();
`endif
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
